pwm_bank: RTL

- Multi-channel PWM generator: one shared period counter drives NUM_CHANNELS compare channels, each with its own duty, phase offset and polarity.
- Successor to the single pwm_cell. Adds:
  - an internal counter with three count modes (up, down, up-down/center-aligned);
  - double-buffered configuration that is applied only at period boundaries;
  - a period-start strobe.
- Sits between the register interface and the pad outputs.

---
 rtl/pwm_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared period counter (up / down / center-aligned)
// feeding per-channel compare stages, with configuration swapped in at period boundaries.
module pwm_bank #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  load,
  input  logic [1:0]                            mode_in,
  input  logic [COUNTER_WIDTH-1:0]              period_in,
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] duty_in,
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] phase_in,
  input  logic [NUM_CHANNELS-1:0]               polarity_in,
  output logic                                  update_pending,
  output logic [COUNTER_WIDTH-1:0]              counter,
  output logic                                  period_start,
  output logic [NUM_CHANNELS-1:0]               pwm
);

  localparam int unsigned W  = COUNTER_WIDTH;
  localparam int unsigned N  = NUM_CHANNELS;
  localparam int unsigned SW = COUNTER_WIDTH + 2;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_UPDOWN = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  typedef struct packed {
    mode_e          mode;
    logic [W-1:0]   period;
    logic [N*W-1:0] duty;
    logic [N*W-1:0] phase;
    logic [N-1:0]   pol;
  } cfg_t;

  cfg_t         act_q, act_d, pend_q, pend_d, in_cfg;
  logic         upd_q, upd_d;
  logic [W-1:0] cnt_q, cnt_d, cnt_step, last_val, start_val;
  dir_e         dir_q, dir_d, dir_step;
  logic         ps_q, ps_d;
  logic [N-1:0] pwm_q, pwm_d, raw;
  logic         wrap, boundary, short_p;

  assign in_cfg = '{mode: mode_e'(mode_in), period: period_in, duty: duty_in,
                    phase: phase_in, pol: polarity_in};

  // Phase-shifted sawtooth compare; two guard bits keep counter+phase exact for any period.
  function automatic logic chan_raw(input logic [W-1:0] cnt, input logic [W-1:0] per,
                                    input logic [W-1:0] duty, input logic [W-1:0] phase,
                                    input mode_e mode);
    logic signed [SW-1:0] ph_s, p_s, s, e;
    p_s  = signed'({2'b00, per});
    ph_s = signed'({{2{phase[W-1]}}, phase});
    if ((ph_s[SW-1] ? -ph_s : ph_s) >= p_s) ph_s = '0;
    s = signed'({2'b00, cnt}) + ph_s;
    if (mode == MODE_UPDOWN) e = signed'({2'b00, cnt});
    else if (s[SW-1])        e = s + p_s;
    else if (s >= p_s)       e = s - p_s;
    else                     e = s;
    return e[W-1:0] < duty;
  endfunction

  always_comb begin
    short_p  = (act_q.period[W-1:1] == '0);
    last_val = act_q.period - 1'b1;
    cnt_step = cnt_q;
    dir_step = dir_q;
    wrap     = 1'b0;
    unique case (act_q.mode)
      MODE_DOWN: begin
        wrap     = (cnt_q == '0);
        cnt_step = cnt_q - 1'b1;
      end
      MODE_UPDOWN: begin
        if (dir_q == DIR_UP && cnt_q != last_val) begin
          cnt_step = cnt_q + 1'b1;
        end else begin
          cnt_step = cnt_q - 1'b1;
          dir_step = DIR_DOWN;
        end
        wrap = (cnt_step == '0);
      end
      default: begin
        wrap     = (cnt_q == last_val);
        cnt_step = cnt_q + 1'b1;
      end
    endcase
    boundary = !enable || short_p || wrap;
  end

  // A load coinciding with the swap still lands in pending, after the old pending moved to active.
  always_comb begin
    act_d  = act_q;
    pend_d = pend_q;
    upd_d  = upd_q;
    if (boundary && upd_q) begin
      act_d = pend_q;
      upd_d = 1'b0;
    end
    if (load) begin
      pend_d = in_cfg;
      upd_d  = 1'b1;
    end
    start_val = (act_d.mode == MODE_DOWN && act_d.period != '0) ? act_d.period - 1'b1 : '0;
    cnt_d     = boundary ? start_val : cnt_step;
    dir_d     = boundary ? DIR_UP : dir_step;
    ps_d      = boundary;
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < N; i++) begin
      raw[i] = chan_raw(cnt_q, act_q.period, act_q.duty[i*W +: W],
                        act_q.phase[i*W +: W], act_q.mode);
    end
    pwm_d = (enable && act_q.period != '0) ? (raw ^ act_q.pol) : act_q.pol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      pend_q <= '0;
      upd_q  <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      ps_q   <= 1'b0;
      pwm_q  <= '0;
    end else begin
      act_q  <= act_d;
      pend_q <= pend_d;
      upd_q  <= upd_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      ps_q   <= ps_d;
      pwm_q  <= pwm_d;
    end
  end

  // While disabled the counter register pre-loads the start value; the port shows 0.
  assign counter        = enable ? cnt_q : '0;
  assign period_start   = enable & ps_q;
  assign update_pending = upd_q;
  assign pwm            = pwm_q;

endmodule
